// File: rtl/dump_stage.sv
// rtl/dump_stage.sv - keccak squeeze stage: serialises rate blocks into a W-bit stream
module dump_stage #(
   parameter int W    = 64,
   parameter int RATE = 1344
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [RATE-1:0] output_buffer_in,
   input  logic            output_buffer_we,
   input  logic [31:0]     output_size,
   output logic            output_buffer_ready,
   input  logic            ready_i,
   output logic            valid_o,
   output logic [W-1:0]    data_out,
   output logic            last_o
);

   localparam int WPB = RATE / W;
   localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
   localparam logic [31:0]   W32       = 32'(W);
   localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

   typedef enum logic {EMPTY, DRAIN} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [RATE-1:0] shreg;
   logic [31:0]     remaining;
   logic [CW-1:0]   word_cnt;

   logic [31:0]     rem_load;
   logic [31:0]     step;
   logic            accept;
   logic            xfer;
   logic            is_last;
   logic            block_end;
   logic [W-1:0]    mask;

   // Handshake decode, next state and stream outputs; remaining==0 marks a message boundary
   always_comb begin
      rem_load  = (remaining == 32'd0) ? output_size : remaining;
      accept    = (state == EMPTY) && output_buffer_we;
      xfer      = (state == DRAIN) && ready_i;
      is_last   = (remaining <= W32);
      block_end = xfer && ((word_cnt == LAST_WORD) || is_last);
      step      = is_last ? remaining : W32;

      state_nxt = state;
      case (state)
         EMPTY:   if (accept && (rem_load != 32'd0)) state_nxt = DRAIN;
         DRAIN:   if (block_end) state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase

      for (int i = 0; i < W; i++) begin
         mask[i] = (32'(i) < remaining);
      end

      output_buffer_ready = (state == EMPTY);
      valid_o             = (state == DRAIN);
      last_o              = valid_o && is_last;
      data_out            = valid_o ? (shreg[W-1:0] & mask) : '0;
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // Block capture, word shift-out and remaining-length bookkeeping
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shreg     <= '0;
         remaining <= 32'd0;
         word_cnt  <= '0;
      end else if (accept) begin
         // a zero-length load leaves remaining at 0 so the block is simply dropped
         shreg     <= output_buffer_in;
         remaining <= rem_load;
         word_cnt  <= '0;
      end else if (xfer) begin
         shreg     <= shreg >> W;
         remaining <= remaining - step;
         word_cnt  <= word_cnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_dump_stage.sv
// tb/tb_dump_stage.sv - scoreboard bench for dump_stage with randomized blocks and backpressure
module tb_dump_stage;

   localparam int W    = 64;
   localparam int RATE = 1344;
   localparam int WPB  = RATE / W;

   logic            clk;
   logic            rst;
   logic [RATE-1:0] output_buffer_in;
   logic            output_buffer_we;
   logic [31:0]     output_size;
   logic            output_buffer_ready;
   logic            ready_i;
   logic            valid_o;
   logic [W-1:0]    data_out;
   logic            last_o;

   dump_stage #(.W(W), .RATE(RATE)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .output_buffer_in    (output_buffer_in),
      .output_buffer_we    (output_buffer_we),
      .output_size         (output_size),
      .output_buffer_ready (output_buffer_ready),
      .ready_i             (ready_i),
      .valid_o             (valid_o),
      .data_out            (data_out),
      .last_o              (last_o)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    beats  = 0;
   int    ready_mode = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Consumer backpressure: 0 = always ready, 1 = random, 2 = 1,0,0 repeating
   initial begin
      int cyc;
      cyc = 0;
      ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = 1'($urandom_range(0, 1));
            default: ready_i = (cyc % 3 == 0);
         endcase
         cyc++;
      end
   end

   // Monitor: pops the scoreboard on each transfer and checks hold-while-stalled
   initial begin
      logic         prev_v, prev_r, prev_l;
      logic [W-1:0] prev_d;
      beat_t        e;
      prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            prev_v = 1'b0;
         end else begin
            if (prev_v && !prev_r) begin
               checks++;
               if (!(valid_o === 1'b1 && data_out === prev_d && last_o === prev_l)) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                           valid_o, data_out, last_o, prev_d, prev_l);
               end
            end
            if (valid_o === 1'b1 && ready_i === 1'b1) begin
               beats++;
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_beat: got d=%h l=%b expected no beat", data_out, last_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("beat_data", data_out, e.data);
                  chk("beat_last", W'(last_o), W'(e.last));
               end
            end
            prev_v = valid_o; prev_r = ready_i; prev_d = data_out; prev_l = last_o;
         end
      end
   end

   // Protocol guard: the producer must never write while the buffer is busy
   initial begin
      forever begin
         @(posedge clk);
         if (rst === 1'b1 && output_buffer_we === 1'b1 && output_buffer_ready !== 1'b1) begin
            errors++;
            $display("FAIL we_while_busy: got ready=%b expected 1", output_buffer_ready);
         end
      end
   end

   function automatic logic [RATE-1:0] gen_block();
      logic [RATE-1:0] b;
      for (int i = 0; i < RATE / 32; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   task automatic wait_buf_ready();
      int n;
      n = 0;
      @(negedge clk);
      #1;
      while (output_buffer_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 1000) begin
         checks++;
         errors++;
         $display("FAIL buf_ready_timeout: got ready=%b expected 1", output_buffer_ready);
      end
   endtask

   task automatic pulse_we(input logic [RATE-1:0] blk);
      output_buffer_in = blk;
      output_buffer_we = 1'b1;
      @(posedge clk);
      #1;
      output_buffer_we = 1'b0;
   endtask

   // Expected stream is the concatenation of the blocks, cut to size bits, in W-bit words
   task automatic push_block(input logic [RATE-1:0] blk, input int b, input int size);
      int           total, hi;
      logic [W-1:0] ones;
      beat_t        e;
      ones  = '1;
      total = (size + W - 1) / W;
      hi    = ((b + 1) * WPB < total) ? (b + 1) * WPB : total;
      for (int j = b * WPB; j < hi; j++) begin
         e.data = blk[(j - b * WPB) * W +: W];
         e.last = (j == total - 1);
         if (j == total - 1 && size % W != 0) e.data = e.data & (ones >> (W - size % W));
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (exp_q.size() != 0 && n < 3000);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
      #1;
      chk("buf_ready_after_msg", W'(output_buffer_ready), W'(1'b1));
      chk("valid_low_after_msg", W'(valid_o), W'(1'b0));
   endtask

   task automatic send_message(input int size, input bit change_size);
      int              total, nblk;
      logic [RATE-1:0] blk;
      total = (size + W - 1) / W;
      nblk  = (total + WPB - 1) / WPB;
      for (int b = 0; b < nblk; b++) begin
         blk = gen_block();
         wait_buf_ready();
         if (b == 0) output_size = 32'(size);
         push_block(blk, b, size);
         pulse_we(blk);
         if (change_size) output_size = $urandom;
      end
      wait_drain();
   endtask

   initial begin
      int base, n;
      logic [RATE-1:0] blk;
      rst = 1'b0;
      output_buffer_in = '0;
      output_buffer_we = 1'b0;
      output_size = 32'd0;

      #12;
      chk("rst_valid", W'(valid_o), W'(1'b0));
      chk("rst_last", W'(last_o), W'(1'b0));
      chk("rst_data", data_out, '0);
      chk("rst_buf_ready", W'(output_buffer_ready), W'(1'b1));
      @(negedge clk);
      rst = 1'b1;

      ready_mode = 0;
      send_message(128, 1'b0);
      send_message(2688, 1'b0);
      send_message(100, 1'b0);
      ready_mode = 2;
      send_message(1344, 1'b0);

      // zero-length request: block is discarded, nothing is emitted
      ready_mode = 0;
      wait_buf_ready();
      output_size = 32'd0;
      pulse_we(gen_block());
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         chk("zero_valid", W'(valid_o), W'(1'b0));
         chk("zero_buf_ready", W'(output_buffer_ready), W'(1'b1));
      end
      chk("zero_remaining", W'(dut.remaining), '0);
      send_message(64, 1'b0);

      // reset in the middle of a two-block message
      wait_buf_ready();
      output_size = 32'd2688;
      blk = gen_block();
      push_block(blk, 0, 2688);
      base = beats;
      pulse_we(blk);
      n = 0;
      while (beats < base + 5 && n < 200) begin
         @(negedge clk);
         #2;
         n++;
      end
      chk("beats_before_reset", W'(beats - base), W'(5));
      rst = 1'b0;
      #1;
      chk("midrst_valid", W'(valid_o), W'(1'b0));
      chk("midrst_last", W'(last_o), W'(1'b0));
      chk("midrst_data", data_out, '0);
      chk("midrst_buf_ready", W'(output_buffer_ready), W'(1'b1));
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      send_message(64, 1'b0);

      // boundaries and random lengths under random backpressure
      ready_mode = 1;
      send_message(1, 1'b1);
      send_message(65, 1'b1);
      send_message(1345, 1'b1);
      send_message(1408, 1'b1);
      for (int i = 0; i < 8; i++) begin
         send_message(int'($urandom_range(1, 4200)), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
